// File: rtl/muldiv_if.sv
// EX-stage request/result bundle between the decoder/operand path and muldiv_unit.
// Signal names follow the unit's port list: _i flows into the unit, _o flows out.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            sel_i;
    logic [1:0]      op_mul_i;
    logic [1:0]      op_div_i;
    logic [XLEN-1:0] opa_i;
    logic [XLEN-1:0] opb_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            done_o;
    logic            busy_o;
    logic            stall_o;

    modport master (
        output start_i, sel_i, op_mul_i, op_div_i, opa_i, opb_i, flush_i,
        input  result_o, done_o, busy_o, stall_o
    );

    modport slave (
        input  start_i, sel_i, op_mul_i, op_div_i, opa_i, opb_i, flush_i,
        output result_o, done_o, busy_o, stall_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign fix-up folded into the final edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk_i,
    input  logic     reset_i,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              sel_q, sel_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              sgn_a_q, sgn_a_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic [2*XLEN-1:0] mul_step, div_step, it, prod;
    logic [XLEN-1:0]   quo_f, rem_f, fin;

    always_comb begin
        // Signedness per op: MULHSU treats opb unsigned, odd div ops are unsigned.
        sa       = bus.opa_i[XLEN-1] & (bus.sel_i ? ~bus.op_div_i[0] : (bus.op_mul_i != 2'b11));
        sb       = bus.opb_i[XLEN-1] & (bus.sel_i ? ~bus.op_div_i[0] : ~bus.op_mul_i[1]);
        mag_a    = sa ? (~bus.opa_i + 1'b1) : bus.opa_i;
        mag_b    = sb ? (~bus.opb_i + 1'b1) : bus.opb_i;
        div_zero = (bus.opb_i == '0);
        div_ovf  = ~bus.op_div_i[0] && (bus.opa_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.opb_i == '1);

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        trial    = rem_sh - {1'b0, b_q};
        div_step = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        it       = sel_q ? div_step : mul_step;

        prod  = neg_q ? (~it + 1'b1) : it;
        quo_f = neg_q ? (~it[XLEN-1:0] + 1'b1) : it[XLEN-1:0];
        rem_f = sgn_a_q ? (~it[2*XLEN-1:XLEN] + 1'b1) : it[2*XLEN-1:XLEN];
        if (sel_q) fin = op_q[1] ? rem_f : quo_f;
        else       fin = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        sel_d    = sel_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: if (bus.start_i) begin
                sel_d   = bus.sel_i;
                op_d    = bus.sel_i ? bus.op_div_i : bus.op_mul_i;
                neg_d   = sa ^ sb;
                sgn_a_d = sa;
                cnt_d   = CW'(XLEN);
                acc_d   = {{XLEN{1'b0}}, bus.sel_i ? mag_a : mag_b};
                b_d     = bus.sel_i ? mag_b : mag_a;
                if (bus.sel_i && (div_zero || div_ovf)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (div_zero) result_d = bus.op_div_i[1] ? bus.opa_i : '1;
                    else          result_d = bus.op_div_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = it;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = fin;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything: abort without touching the visible result.
        if (bus.flush_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            sgn_a_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sgn_a_q  <= sgn_a_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.stall_o  = ~reset_i & (((state_q == S_IDLE) & bus.start_i & ~bus.flush_i)
                                      | (state_q == S_RUN));
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: result values, completion cycle, flush and reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // Stimulus only: issue one op in the current (IDLE) cycle, report the cycle
    // done_o was seen in (0 = issue cycle) and the result, then step to the next cycle.
    task automatic issue(input logic sel, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc, output logic [31:0] res,
                         output logic stall0);
        bus.sel_i = sel; bus.op_mul_i = op; bus.op_div_i = op;
        bus.opa_i = a;   bus.opb_i = b;     bus.start_i = 1'b1;
        #1 stall0 = bus.stall_o;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.opa_i = 32'h5A5A_1234; bus.opb_i = 32'hDEAD_BEEF;
        cyc = 1;
        while (!bus.done_o && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = bus.result_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        bus.start_i = 1'b0; bus.sel_i = 1'b0; bus.op_mul_i = 2'b00; bus.op_div_i = 2'b00;
        bus.opa_i = '0; bus.opb_i = '0; bus.flush_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        n_vec++; if (bus.done_o !== 1'b0)    begin n_err++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        n_vec++; if (bus.busy_o !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        n_vec++; if (bus.stall_o !== 1'b0)   begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        int c; logic [31:0] r; logic s;
        issue(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7, c, r, s);
        n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL mul_stall_c0 got %b want 1", s); end
        n_vec++; if (c != 33) begin n_err++; $display("FAIL mul_latency got %0d want 33", c); end
        n_vec++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul got %h want ffffffeb", r); end
        n_vec++; if (bus.busy_o !== 1'b0 || bus.result_o !== 32'hFFFF_FFEB) begin
            n_err++; $display("FAIL mul_hold busy %b result %h want 0 ffffffeb", bus.busy_o, bus.result_o); end
        issue(1'b0, 2'b11, 32'hFFFF_FFFD, 32'd7, c, r, s);
        n_vec++; if (c != 33 || r !== 32'h0000_0006) begin n_err++; $display("FAIL mulhu got %h@%0d want 00000006@33", r, c); end
        issue(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, c, r, s);
        n_vec++; if (c != 33 || r !== 32'h4000_0000) begin n_err++; $display("FAIL mulh got %h@%0d want 40000000@33", r, c); end
        issue(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, r, s);
        n_vec++; if (c != 33 || r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu got %h@%0d want ffffffff@33", r, c); end
        issue(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, r, s);
        n_vec++; if (c != 33 || r !== 32'h0000_0000) begin n_err++; $display("FAIL mulh_m1 got %h@%0d want 00000000@33", r, c); end
    endtask

    task automatic test_div_special;
        int c; logic [31:0] r; logic s;
        issue(1'b1, 2'b01, 32'd100, 32'd0, c, r, s);
        n_vec++; if (c != 1 || r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_by0 got %h@%0d want ffffffff@1", r, c); end
        issue(1'b1, 2'b11, 32'd100, 32'd0, c, r, s);
        n_vec++; if (c != 1 || r !== 32'd100) begin n_err++; $display("FAIL remu_by0 got %h@%0d want 00000064@1", r, c); end
        issue(1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, c, r, s);
        n_vec++; if (c != 1 || r !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf got %h@%0d want 80000000@1", r, c); end
        issue(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, c, r, s);
        n_vec++; if (c != 1 || r !== 32'h0) begin n_err++; $display("FAIL rem_ovf got %h@%0d want 00000000@1", r, c); end
        issue(1'b1, 2'b00, 32'hFFFF_FFF9, 32'd0, c, r, s);
        n_vec++; if (c != 1 || r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_by0 got %h@%0d want ffffffff@1", r, c); end
    endtask

    task automatic test_div;
        int c; logic [31:0] r; logic s;
        issue(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, c, r, s);
        n_vec++; if (c != 33 || r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem got %h@%0d want ffffffff@33", r, c); end
        issue(1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2, c, r, s);
        n_vec++; if (c != 33 || r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div got %h@%0d want fffffffd@33", r, c); end
        issue(1'b1, 2'b00, 32'd100, 32'hFFFF_FFF9, c, r, s);
        n_vec++; if (c != 33 || r !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL div_negb got %h@%0d want fffffff2@33", r, c); end
        issue(1'b1, 2'b11, 32'd1000, 32'd7, c, r, s);
        n_vec++; if (c != 33 || r !== 32'd6) begin n_err++; $display("FAIL remu got %h@%0d want 00000006@33", r, c); end
        issue(1'b1, 2'b01, 32'hFFFF_FFFF, 32'd16, c, r, s);
        n_vec++; if (c != 33 || r !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL divu got %h@%0d want 0fffffff@33", r, c); end
    endtask

    task automatic test_flush;
        int c; logic [31:0] r; logic s; int seen_done;
        seen_done = 0;
        bus.sel_i = 1'b1; bus.op_div_i = 2'b00; bus.op_mul_i = 2'b00;
        bus.opa_i = 32'd1000; bus.opb_i = 32'd3; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (bus.done_o) seen_done++;
            @(posedge clk); #1;
        end
        bus.flush_i = 1'b1; bus.start_i = 1'b1;
        #1;
        n_vec++; if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            n_err++; $display("FAIL flush_c10 stall %b busy %b want 1 1", bus.stall_o, bus.busy_o); end
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        n_vec++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || seen_done != 0) begin
            n_err++; $display("FAIL flush_idle busy %b done %b early_done %0d want 0 0 0", bus.busy_o, bus.done_o, seen_done); end
        n_vec++; if (bus.result_o !== 32'h0FFF_FFFF) begin
            n_err++; $display("FAIL flush_keep got %h want 0fffffff", bus.result_o); end
        issue(1'b0, 2'b00, 32'd5, 32'd6, c, r, s);
        n_vec++; if (c != 33 || r !== 32'd30) begin n_err++; $display("FAIL mul_after_flush got %h@%0d want 0000001e@33", r, c); end
    endtask

    task automatic test_reset_mid;
        int c, gap;
        bus.sel_i = 1'b0; bus.op_mul_i = 2'b00; bus.opa_i = 32'd12; bus.opb_i = 32'd12;
        bus.start_i = 1'b1;
        for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (bus.result_o !== 32'h0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL reset_mid result %h busy %b done %b want 0 0 0", bus.result_o, bus.busy_o, bus.done_o); end
        c = 0;
        while (!bus.done_o && c < 100) begin @(posedge clk); #1; c++; end
        n_vec++; if (c != 33 || bus.result_o !== 32'd144) begin
            n_err++; $display("FAIL held_first got %h@%0d want 00000090@33", bus.result_o, c); end
        gap = 0;
        do begin @(posedge clk); #1; gap++; end while (!bus.done_o && gap < 100);
        n_vec++; if (gap != 34) begin n_err++; $display("FAIL back_to_back gap got %0d want 34", gap); end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus.busy_o !== 1'b0 || bus.result_o !== 32'd144) begin
            n_err++; $display("FAIL b2b_end busy %b result %h want 0 00000090", bus.busy_o, bus.result_o); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_special();
        test_div();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
